// File: rtl/mm_game_ctrl.sv
// mm_game_ctrl
// Game sequencer for an external win/loss counter. Commands (INIT loads or
// ctrl-mode steps) are buffered in a small FIFO and issued to the counter one
// per cycle while a game is in PLAY. The game ends when either tally reaches
// WIN_TARGET; the buffer is then flushed and the completed-game count bumps.
//
// Ports:
//   dclk, arst            clock, asynchronous active-high reset
//   start                 pulse: IDLE->PLAY, OVER->IDLE
//   cmd_valid/cmd_ready   command handshake
//   cmd_init/ctrl/inval   command payload
//   INIT, inval, ctrl     registered command outputs to the counter
//   ctr_arstn             registered active-low reset to the counter
//   W_count, L_count      tallies from the counter
//   WINNER, LOSER         game result flags (registered)
//   GAMEOVER              high while in OVER (registered)
//   games                 completed-game count, wraps at 256
module mm_game_ctrl #(
    parameter logic [3:0]  WIN_TARGET = 4'd15,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [1:0]  DEF_CTRL   = 2'b00
) (
    input  logic       dclk,
    input  logic       arst,
    input  logic       start,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_init,
    input  logic [1:0] cmd_ctrl,
    input  logic [3:0] cmd_inval,
    output logic       INIT,
    output logic [3:0] inval,
    output logic [1:0] ctrl,
    output logic       ctr_arstn,
    input  logic [3:0] W_count,
    input  logic [3:0] L_count,
    output logic       WINNER,
    output logic       LOSER,
    output logic       GAMEOVER,
    output logic [7:0] games
);

    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    typedef enum logic [1:0] {IDLE, PLAY, OVER} state_t;

    state_t        state;
    logic [6:0]    mem [FIFO_DEPTH];   // {init, ctrl[1:0], inval[3:0]}
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [6:0]    head;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic          w_hit;
    logic          l_hit;
    logic          game_end;

    assign full      = (count == (AW+1)'(FIFO_DEPTH));
    assign empty     = (count == '0);
    assign cmd_ready = !full && (state != OVER);
    assign push      = cmd_valid && cmd_ready;
    assign w_hit     = (W_count == WIN_TARGET);
    assign l_hit     = (L_count == WIN_TARGET);
    assign game_end  = (state == PLAY) && (w_hit || l_hit);
    // No issue on the game-ending cycle: the flush discards the buffer and
    // the counter sees defaults as the game enters OVER.
    assign pop       = (state == PLAY) && !empty && !game_end;
    assign head      = mem[rd_ptr];

    // Payload storage needs no reset; occupancy is tracked by count.
    always_ff @(posedge dclk) begin
        if (push)
            mem[wr_ptr] <= {cmd_init, cmd_ctrl, cmd_inval};
    end

    always_ff @(posedge dclk or posedge arst) begin
        if (arst) begin
            state     <= IDLE;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            INIT      <= 1'b0;
            inval     <= '0;
            ctrl      <= DEF_CTRL;
            ctr_arstn <= 1'b0;
            WINNER    <= 1'b0;
            LOSER     <= 1'b0;
            GAMEOVER  <= 1'b0;
            games     <= '0;
        end else begin
            // Buffer bookkeeping
            if (game_end) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push)
                    wr_ptr <= wr_ptr + 1'b1;
                if (pop)
                    rd_ptr <= rd_ptr + 1'b1;
                case ({push, pop})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end

            // Command outputs, one cycle after the pop decision
            if (pop) begin
                INIT  <= head[6];
                ctrl  <= head[5:4];
                inval <= head[3:0];
            end else begin
                INIT  <= 1'b0;
                ctrl  <= DEF_CTRL;
                inval <= '0;
            end

            // Counter reset pulses low only on the OVER->IDLE transition
            ctr_arstn <= 1'b1;

            case (state)
                IDLE: begin
                    if (start)
                        state <= PLAY;
                end
                PLAY: begin
                    if (w_hit) begin
                        state    <= OVER;
                        WINNER   <= 1'b1;
                        LOSER    <= 1'b0;
                        GAMEOVER <= 1'b1;
                        games    <= games + 1'b1;
                    end else if (l_hit) begin
                        state    <= OVER;
                        WINNER   <= 1'b0;
                        LOSER    <= 1'b1;
                        GAMEOVER <= 1'b1;
                        games    <= games + 1'b1;
                    end
                end
                OVER: begin
                    if (start) begin
                        state     <= IDLE;
                        WINNER    <= 1'b0;
                        LOSER     <= 1'b0;
                        GAMEOVER  <= 1'b0;
                        ctr_arstn <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mm_game_ctrl.sv
module tb_mm_game_ctrl;

    localparam logic [1:0] DEF   = 2'b01;   // distinct from ctrl=00 commands
    localparam int         DEPTH = 4;
    localparam logic [3:0] TGT   = 4'd15;

    logic       dclk;
    logic       arst;
    logic       start;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_init;
    logic [1:0] cmd_ctrl;
    logic [3:0] cmd_inval;
    logic       INIT;
    logic [3:0] inval;
    logic [1:0] ctrl;
    logic       ctr_arstn;
    logic [3:0] W_count;
    logic [3:0] L_count;
    logic       WINNER;
    logic       LOSER;
    logic       GAMEOVER;
    logic [7:0] games;

    mm_game_ctrl #(
        .WIN_TARGET(TGT),
        .FIFO_DEPTH(DEPTH),
        .DEF_CTRL(DEF)
    ) dut (
        .dclk(dclk), .arst(arst), .start(start),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_init(cmd_init), .cmd_ctrl(cmd_ctrl), .cmd_inval(cmd_inval),
        .INIT(INIT), .inval(inval), .ctrl(ctrl), .ctr_arstn(ctr_arstn),
        .W_count(W_count), .L_count(L_count),
        .WINNER(WINNER), .LOSER(LOSER), .GAMEOVER(GAMEOVER), .games(games)
    );

    initial dclk = 1'b0;
    always #5 dclk = ~dclk;

    int errors = 0;
    int checks = 0;
    bit en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: game phase plus a queue of pending commands
    localparam int P_IDLE = 0, P_PLAY = 1, P_OVER = 2;
    int         ph;
    logic [6:0] q[$];
    logic [6:0] c;
    bit         acc;
    logic       e_init, e_arstn, e_win, e_lose, e_over;
    logic [3:0] e_inval;
    logic [1:0] e_ctrl;
    logic [7:0] e_games;

    always @(posedge dclk or posedge arst) begin
        if (arst) begin
            ph = P_IDLE; q.delete();
            e_init = 0; e_inval = 0; e_ctrl = DEF; e_arstn = 0;
            e_win = 0; e_lose = 0; e_over = 0; e_games = 0;
        end else begin
            acc = cmd_valid && (q.size() < DEPTH) && (ph != P_OVER);
            e_init = 0; e_inval = 0; e_ctrl = DEF; e_arstn = 1;
            if (ph == P_IDLE) begin
                if (acc) q.push_back({cmd_init, cmd_ctrl, cmd_inval});
                if (start) ph = P_PLAY;
            end else if (ph == P_PLAY) begin
                if (W_count == TGT || L_count == TGT) begin
                    e_win = (W_count == TGT);
                    e_lose = !e_win;
                    e_over = 1;
                    e_games = e_games + 8'd1;
                    q.delete();
                    ph = P_OVER;
                end else begin
                    if (q.size() > 0) begin
                        c = q.pop_front();
                        e_init = c[6]; e_ctrl = c[5:4]; e_inval = c[3:0];
                    end
                    if (acc) q.push_back({cmd_init, cmd_ctrl, cmd_inval});
                end
            end else begin
                if (start) begin
                    ph = P_IDLE;
                    e_win = 0; e_lose = 0; e_over = 0; e_arstn = 0;
                end
            end
        end
    end

    always @(negedge dclk) begin
        if (en) begin
            chk("m_INIT", INIT, e_init);
            chk("m_inval", inval, e_inval);
            chk("m_ctrl", ctrl, e_ctrl);
            chk("m_ctr_arstn", ctr_arstn, e_arstn);
            chk("m_WINNER", WINNER, e_win);
            chk("m_LOSER", LOSER, e_lose);
            chk("m_GAMEOVER", GAMEOVER, e_over);
            chk("m_games", games, e_games);
            chk("m_cmd_ready", cmd_ready, (q.size() < DEPTH) && (ph != P_OVER));
        end
    end

    task automatic tick();
        @(posedge dclk);
        #1;
    endtask

    task automatic push1(input logic i, input logic [1:0] cc, input logic [3:0] v);
        cmd_valid = 1; cmd_init = i; cmd_ctrl = cc; cmd_inval = v;
        tick();
        cmd_valid = 0;
    endtask

    task automatic pulse_start();
        start = 1;
        tick();
        start = 0;
    endtask

    initial begin
        arst = 0; start = 0; cmd_valid = 0; cmd_init = 0; cmd_ctrl = 0;
        cmd_inval = 0; W_count = 0; L_count = 0;
        #3 arst = 1; en = 1;
        #1;
        chk("rst_INIT", INIT, 0);
        chk("rst_ctrl", ctrl, DEF);
        chk("rst_ctr_arstn", ctr_arstn, 0);
        chk("rst_games", games, 0);
        chk("rst_GAMEOVER", GAMEOVER, 0);
        chk("rst_cmd_ready", cmd_ready, 1);
        tick(); tick();
        arst = 0;
        tick();
        chk("arstn_rise", ctr_arstn, 1);

        // Basic game: load then step, win by W_count
        pulse_start();
        push1(1, 2'b00, 4'd14);
        push1(0, 2'b00, 4'd0);
        chk("first_INIT", INIT, 1);
        chk("first_inval", inval, 14);
        tick();
        chk("second_INIT", INIT, 0);
        chk("second_ctrl", ctrl, 2'b00);
        tick();
        chk("empty_ctrl", ctrl, DEF);
        W_count = 15; tick(); W_count = 0;
        chk("win_WINNER", WINNER, 1);
        chk("win_GAMEOVER", GAMEOVER, 1);
        chk("win_games", games, 1);
        chk("over_ready", cmd_ready, 0);
        pulse_start();
        chk("restart_arstn", ctr_arstn, 0);
        chk("restart_WINNER", WINNER, 0);
        tick();
        chk("restart_arstn_hi", ctr_arstn, 1);

        // Fill buffer in IDLE; 5th waits for a PLAY pop
        for (int i = 0; i < 4; i++)
            push1(1'(i % 2), 2'(i + 2), 4'(i + 3));
        chk("full_ready", cmd_ready, 0);
        cmd_valid = 1; cmd_init = 1; cmd_ctrl = 2'b11; cmd_inval = 4'd9;
        pulse_start();
        chk("still_full", cmd_ready, 0);
        tick();
        chk("pop0_INIT", INIT, 0);
        chk("pop0_ctrl", ctrl, 2);
        chk("pop0_inval", inval, 3);
        chk("slot_free", cmd_ready, 1);
        tick();
        cmd_valid = 0;
        repeat (5) tick();
        L_count = 15; tick(); L_count = 0;
        chk("lose_LOSER", LOSER, 1);
        chk("lose_WINNER", WINNER, 0);
        chk("lose_games", games, 2);
        pulse_start();

        // Tie with queued data: WINNER priority, queue never issued
        for (int i = 0; i < 4; i++)
            push1(1, 2'(i), 4'(i + 7));
        pulse_start();
        W_count = 15; L_count = 15; tick(); W_count = 0; L_count = 0;
        chk("tie_WINNER", WINNER, 1);
        chk("tie_LOSER", LOSER, 0);
        chk("tie_INIT", INIT, 0);
        pulse_start();
        chk("tie_arstn", ctr_arstn, 0);
        tick();
        pulse_start();
        repeat (3) begin
            tick();
            chk("flushed_INIT", INIT, 0);
            chk("flushed_ctrl", ctrl, DEF);
        end
        W_count = 15; tick(); W_count = 0;
        pulse_start();

        // Reset mid-PLAY with 3 commands still queued
        push1(1, 2'b11, 4'd5);
        push1(0, 2'b10, 4'd6);
        push1(1, 2'b00, 4'd7);
        push1(0, 2'b11, 4'd8);
        pulse_start();
        tick();
        chk("pre_rst_INIT", INIT, 1);
        chk("pre_rst_inval", inval, 5);
        arst = 1;
        #1;
        chk("mid_rst_INIT", INIT, 0);
        chk("mid_rst_inval", inval, 0);
        chk("mid_rst_ctrl", ctrl, DEF);
        chk("mid_rst_arstn", ctr_arstn, 0);
        chk("mid_rst_games", games, 0);
        tick(); tick();
        arst = 0;
        tick();
        pulse_start();
        repeat (2) begin
            tick();
            chk("post_rst_INIT", INIT, 0);
            chk("post_rst_ctrl", ctrl, DEF);
        end
        W_count = 15; tick(); W_count = 0;
        chk("g1_games", games, 1);
        pulse_start();

        // Game counter wrap
        for (int g = 2; g <= 256; g++) begin
            pulse_start();
            W_count = 15; tick(); W_count = 0;
            if (g == 255) chk("games_255", games, 255);
            if (g == 256) chk("games_wrap", games, 0);
            pulse_start();
        end
        tick();

        en = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mm_game_ctrl.md
MM_GAME_CTRL -- requirements
Module: mm_game_ctrl

Interface
REQ-001 SHALL have parameter WIN_TARGET, default 4'd15: W_count/L_count value that ends a game.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4: command buffer entries (power of 2, 2..16).
REQ-003 SHALL have parameter DEF_CTRL, default 2'b00: ctrl driven when no command is issued.
REQ-004 SHALL have port dclk  input  1  single clock; all state on posedge dclk.
REQ-005 SHALL have port arst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port start  input  1  one-cycle pulse; begins a game from IDLE.
REQ-007 SHALL have port cmd_valid  input  1  command present.
REQ-008 SHALL have port cmd_ready  output  1  command buffer can accept.
REQ-009 SHALL have port cmd_init  input  1  command is a load (INIT) rather than a ctrl step.
REQ-010 SHALL have port cmd_ctrl  input  2  counter mode for the command.
REQ-011 SHALL have port cmd_inval  input  4  load value for the command.
REQ-012 SHALL have port INIT  output  1  to counter: load inval this cycle.
REQ-013 SHALL have port inval  output  4  to counter: load value.
REQ-014 SHALL have port ctrl  output  2  to counter: mode.
REQ-015 SHALL have port ctr_arstn  output  1  to counter: active-low reset, registered.
REQ-016 SHALL have port W_count  input  4  from counter: win tally.
REQ-017 SHALL have port L_count  input  4  from counter: loss tally.
REQ-018 SHALL have port WINNER  output  1  game ended by W_count.
REQ-019 SHALL have port LOSER  output  1  game ended by L_count.
REQ-020 SHALL have port GAMEOVER  output  1  high in OVER state.
REQ-021 SHALL have port games  output  8  completed-game count, wraps 255->0.

Function
REQ-022 SHALL implement FSM states IDLE, PLAY, OVER.
REQ-023 IDLE: start=1 -> PLAY next cycle; otherwise stay.
REQ-024 PLAY: W_count==WIN_TARGET -> OVER with WINNER=1; else L_count==WIN_TARGET -> OVER with LOSER=1; both equal same cycle -> WINNER priority, LOSER=0.
REQ-025 OVER: start=1 -> IDLE, ctr_arstn=0 for exactly that one following cycle, WINNER/LOSER cleared; otherwise hold.
REQ-026 Command handshake: transfer when cmd_valid && cmd_ready; cmd_ready = !full && state!=OVER.
REQ-027 Commands accepted in IDLE SHALL be queued but not issued.
REQ-028 In PLAY, each cycle with buffer non-empty SHALL pop one entry and register it onto INIT/inval/ctrl (1-cycle latency from pop to outputs).
REQ-029 In PLAY with buffer empty, or in IDLE/OVER, outputs SHALL be INIT=0, inval=4'd0, ctrl=DEF_CTRL.
REQ-030 Push and pop in same cycle while full SHALL NOT occur (cmd_ready=0); push and pop same cycle while non-full SHALL keep occupancy unchanged.
REQ-031 Push into empty buffer in PLAY SHALL issue no earlier than the next cycle (no bypass).
REQ-032 Entry into OVER SHALL flush the buffer (occupancy 0) and increment games by 1.
REQ-033 start in PLAY SHALL be ignored.
REQ-034 WINNER, LOSER, GAMEOVER SHALL be registered outputs, mutually consistent: WINNER|LOSER implies GAMEOVER.

Reset
REQ-035 arst=1 SHALL immediately force IDLE, empty buffer, games=0, WINNER=LOSER=GAMEOVER=0, INIT=0, inval=0, ctrl=DEF_CTRL, ctr_arstn=0.
REQ-036 ctr_arstn SHALL rise to 1 on the first dclk edge after arst deasserts.
REQ-037 arst mid-PLAY with queued commands SHALL discard them; no command issues after reset.

Verification
REQ-038 Reset, start, push {init=1,inval=14} then {init=0,ctrl=00} -> INIT=1/inval=14 one cycle after first pop, then ctrl=00; W_count driven 15 -> WINNER=1, GAMEOVER=1, games=1.
REQ-039 Push 5 commands while IDLE (depth 4) -> cmd_ready=0 after 4th; 5th held until PLAY pop frees a slot.
REQ-040 PLAY, W_count=15 and L_count=15 same cycle -> WINNER=1, LOSER=0.
REQ-041 OVER, then start -> ctr_arstn=0 for exactly one cycle, state IDLE, WINNER=0; queued data from before OVER never issued.
REQ-042 arst asserted mid-PLAY with 3 queued commands -> all outputs at reset values asynchronously; after release + start, empty buffer yields ctrl=DEF_CTRL, INIT=0.
REQ-043 256 completed games -> games wraps to 0.
